// File: rtl/main_memory_burst.sv
`default_nettype none
// ============================================================================
//  Module      : main_memory_burst
//  Description : Writable main-memory model serving wrapped, critical-word-
//                first line bursts with programmable read/write latency.
//  Revision    : 1.0 - initial release
// ============================================================================
module main_memory_burst #(
    parameter int DATA_W     = 32,
    parameter int DEPTH      = 1024,
    parameter int BURST_LEN  = 4,
    parameter int RD_LATENCY = 3,
    parameter int WR_LATENCY = 2
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                en,
    input  logic                rd_wr,
    input  logic [31:0]         addr,
    input  logic [DATA_W-1:0]   wr_data,
    input  logic [DATA_W/8-1:0] wr_be,
    output logic                ready,
    output logic                rd_valid,
    output logic [DATA_W-1:0]   rd_data,
    output logic                rd_last,
    output logic                wr_ack
);

    localparam int BYTES   = DATA_W / 8;
    localparam int AW      = $clog2(DEPTH);
    localparam int BEAT_W  = (BURST_LEN > 1) ? $clog2(BURST_LEN) : 1;
    localparam int LAT_MAX = (RD_LATENCY > WR_LATENCY) ? RD_LATENCY : WR_LATENCY;
    localparam int LAT_W   = (LAT_MAX > 1) ? $clog2(LAT_MAX) : 1;

    localparam logic [AW-1:0]     LINE_MASK   = AW'(BURST_LEN - 1);
    localparam logic [BEAT_W-1:0] LAST_BEAT   = BEAT_W'(BURST_LEN - 1);
    localparam logic [LAT_W-1:0]  RD_LAT_INIT = LAT_W'(RD_LATENCY - 1);
    localparam logic [LAT_W-1:0]  WR_LAT_INIT = LAT_W'(WR_LATENCY - 1);

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        RD_WAIT  = 2'd1,
        RD_BURST = 2'd2,
        WR_WAIT  = 2'd3
    } state_t;

    logic [DATA_W-1:0] mem [DEPTH];

    state_t            state,      state_next;
    logic [LAT_W-1:0]  lat_cnt,    lat_next;
    logic [BEAT_W-1:0] beat_cnt,   beat_next;
    logic [AW-1:0]     base,       base_next;
    logic [DATA_W-1:0] wdata_q,    wdata_next;
    logic [BYTES-1:0]  wbe_q,      wbe_next;
    logic              rd_valid_next;
    logic              rd_last_next;
    logic [DATA_W-1:0] rd_data_next;
    logic              wr_ack_next;

    logic [AW-1:0]     beat_idx;
    logic              mem_we;
    logic              unused_addr_bits;

    assign unused_addr_bits = ^{addr[31:AW+2], addr[1:0]};

    // Wrap inside the aligned line: upper bits from base, low bits advance mod BURST_LEN.
    assign beat_idx = (base & ~LINE_MASK) | ((base + AW'(beat_cnt)) & LINE_MASK);
    assign mem_we   = (state == WR_WAIT) && (lat_cnt == '0);
    assign ready    = (state == IDLE);

    always_comb begin
        state_next    = state;
        lat_next      = lat_cnt;
        beat_next     = beat_cnt;
        base_next     = base;
        wdata_next    = wdata_q;
        wbe_next      = wbe_q;
        rd_valid_next = 1'b0;
        rd_last_next  = 1'b0;
        rd_data_next  = rd_data;
        wr_ack_next   = 1'b0;

        case (state)
            IDLE: begin
                beat_next = '0;
                if (en) begin
                    base_next = addr[AW+1:2];
                    if (rd_wr) begin
                        lat_next   = RD_LAT_INIT;
                        state_next = RD_WAIT;
                    end else begin
                        wdata_next = wr_data;
                        wbe_next   = wr_be;
                        lat_next   = WR_LAT_INIT;
                        state_next = WR_WAIT;
                    end
                end
            end

            RD_WAIT: begin
                if (lat_cnt == '0) begin
                    // First beat is launched on the same edge that leaves RD_WAIT.
                    state_next    = RD_BURST;
                    rd_valid_next = 1'b1;
                    rd_data_next  = mem[beat_idx];
                    rd_last_next  = (beat_cnt == LAST_BEAT);
                    beat_next     = beat_cnt + 1'b1;
                end else begin
                    lat_next = lat_cnt - 1'b1;
                end
            end

            RD_BURST: begin
                if (rd_last) begin
                    state_next = IDLE;
                    beat_next  = '0;
                end else begin
                    rd_valid_next = 1'b1;
                    rd_data_next  = mem[beat_idx];
                    rd_last_next  = (beat_cnt == LAST_BEAT);
                    beat_next     = beat_cnt + 1'b1;
                end
            end

            WR_WAIT: begin
                if (lat_cnt == '0) begin
                    wr_ack_next = 1'b1;
                    state_next  = IDLE;
                end else begin
                    lat_next = lat_cnt - 1'b1;
                end
            end

            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state    <= IDLE;
            lat_cnt  <= '0;
            beat_cnt <= '0;
            base     <= '0;
            wdata_q  <= '0;
            wbe_q    <= '0;
            rd_valid <= 1'b0;
            rd_last  <= 1'b0;
            rd_data  <= '0;
            wr_ack   <= 1'b0;
        end else begin
            state    <= state_next;
            lat_cnt  <= lat_next;
            beat_cnt <= beat_next;
            base     <= base_next;
            wdata_q  <= wdata_next;
            wbe_q    <= wbe_next;
            rd_valid <= rd_valid_next;
            rd_last  <= rd_last_next;
            rd_data  <= rd_data_next;
            wr_ack   <= wr_ack_next;
        end
    end

    // Storage is deliberately outside the reset domain so contents survive reset.
    always_ff @(posedge clk) begin
        if (mem_we) begin
            for (int i = 0; i < BYTES; i++) begin
                if (wbe_q[i]) begin
                    mem[base][i*8 +: 8] <= wdata_q[i*8 +: 8];
                end
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_main_memory_burst.sv
`default_nettype none
// ============================================================================
//  Module      : tb_main_memory_burst
//  Description : Directed self-checking bench for main_memory_burst.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_main_memory_burst;

    logic        clk;
    logic        reset;
    logic        en;
    logic        rd_wr;
    logic [31:0] addr;
    logic [31:0] wr_data;
    logic [3:0]  wr_be;
    logic        ready;
    logic        rd_valid;
    logic [31:0] rd_data;
    logic        rd_last;
    logic        wr_ack;

    int          n_checks = 0;
    int          n_fail   = 0;
    logic [31:0] beats [8];
    int          n_beats;
    int          first_lat;
    int          last_idx;
    int          ack_lat;

    main_memory_burst #(
        .DATA_W     (32),
        .DEPTH      (1024),
        .BURST_LEN  (4),
        .RD_LATENCY (3),
        .WR_LATENCY (2)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .en       (en),
        .rd_wr    (rd_wr),
        .addr     (addr),
        .wr_data  (wr_data),
        .wr_be    (wr_be),
        .ready    (ready),
        .rd_valid (rd_valid),
        .rd_data  (rd_data),
        .rd_last  (rd_last),
        .wr_ack   (wr_ack)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic do_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] be);
        @(negedge clk);
        check("wr_ready", {31'd0, ready}, 32'd1);
        en = 1'b1; rd_wr = 1'b0; addr = a; wr_data = d; wr_be = be;
        @(posedge clk);
        @(negedge clk);
        en = 1'b0;
        ack_lat = -1;
        for (int c = 1; c <= 10; c++) begin
            @(posedge clk);
            @(negedge clk);
            if (wr_ack) begin
                ack_lat = c;
                break;
            end
        end
        @(posedge clk);
        @(negedge clk);
        check("wr_ack_pulse", {31'd0, wr_ack}, 32'd0);
    endtask

    // hold: keep en high with hold_addr until the first beat; reset_after: beat index after which reset fires
    task automatic do_read(input logic [31:0] a, input logic [31:0] hold_addr,
                           input bit hold, input int reset_after);
        @(negedge clk);
        check("rd_ready", {31'd0, ready}, 32'd1);
        en = 1'b1; rd_wr = 1'b1; addr = a;
        @(posedge clk);
        @(negedge clk);
        if (hold) addr = hold_addr;
        else      en = 1'b0;
        n_beats = 0; first_lat = -1; last_idx = -1;
        for (int c = 1; c <= 12; c++) begin
            @(posedge clk);
            @(negedge clk);
            if (rd_valid) begin
                en = 1'b0;
                if (n_beats < 8) beats[n_beats] = rd_data;
                if (rd_last && last_idx < 0) last_idx = n_beats;
                if (first_lat < 0) first_lat = c;
                n_beats++;
                if (reset_after >= 0 && n_beats == reset_after + 1) begin
                    reset = 1'b1;
                    #1;
                    check("rst_rd_valid", {31'd0, rd_valid}, 32'd0);
                    check("rst_ready",    {31'd0, ready},    32'd1);
                    check("rst_rd_data",  rd_data,           32'd0);
                    @(negedge clk);
                    reset = 1'b0;
                end
            end
        end
    endtask

    initial begin
        reset = 1'b1; en = 1'b0; rd_wr = 1'b0; addr = '0; wr_data = '0; wr_be = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("reset_ready",    {31'd0, ready},    32'd1);
        check("reset_rd_valid", {31'd0, rd_valid}, 32'd0);
        check("reset_rd_last",  {31'd0, rd_last},  32'd0);
        check("reset_wr_ack",   {31'd0, wr_ack},   32'd0);
        check("reset_rd_data",  rd_data,           32'd0);
        reset = 1'b0;

        do_write(32'h44, 32'h4444_4444, 4'hF);
        do_write(32'h48, 32'h4848_4848, 4'hF);
        do_write(32'h4C, 32'h4C4C_4C4C, 4'hF);

        // Write then read the same line, critical word at offset 0
        do_write(32'h40, 32'hDEAD_BEEF, 4'hF);
        check("t2_ack_lat", ack_lat, 32'd2);
        do_read(32'h40, 32'h0, 1'b0, -1);
        check("t2_n_beats", n_beats,  32'd4);
        check("t2_beat0",   beats[0], 32'hDEAD_BEEF);
        check("t2_beat1",   beats[1], 32'h4444_4444);
        check("t2_beat2",   beats[2], 32'h4848_4848);
        check("t2_beat3",   beats[3], 32'h4C4C_4C4C);
        check("t2_last",    last_idx, 32'd3);

        // Wrapped burst starting mid-line
        do_read(32'h48, 32'h0, 1'b0, -1);
        check("t3_first_lat", first_lat, 32'd3);
        check("t3_n_beats",   n_beats,   32'd4);
        check("t3_beat0",     beats[0],  32'h4848_4848);
        check("t3_beat1",     beats[1],  32'h4C4C_4C4C);
        check("t3_beat2",     beats[2],  32'hDEAD_BEEF);
        check("t3_beat3",     beats[3],  32'h4444_4444);
        check("t3_last",      last_idx,  32'd3);
        check("t3_hold",      rd_data,   32'h4444_4444);

        // en held through RD_WAIT with another address
        do_read(32'h40, 32'h100, 1'b1, -1);
        check("t5_n_beats", n_beats,  32'd4);
        check("t5_beat0",   beats[0], 32'hDEAD_BEEF);
        check("t5_beat3",   beats[3], 32'h4C4C_4C4C);

        // Reset mid-burst after beat 1
        do_read(32'h40, 32'h0, 1'b0, 1);
        check("t1_n_beats", n_beats,  32'd2);
        check("t1_beat1",   beats[1], 32'h4444_4444);

        // Byte-enabled merge, then an all-disabled write
        do_write(32'h10, 32'h1122_3344, 4'hF);
        do_write(32'h10, 32'hAABB_CCDD, 4'b0101);
        do_read(32'h10, 32'h0, 1'b0, -1);
        check("t4_merge", beats[0], 32'h11BB_33DD);
        do_write(32'h10, 32'hFFFF_FFFF, 4'h0);
        check("t4_be0_ack", ack_lat, 32'd2);
        do_read(32'h10, 32'h0, 1'b0, -1);
        check("t4_be0_keep", beats[0], 32'h11BB_33DD);

        // Aliasing above DEPTH words
        do_write(32'h0, 32'h0BAD_F00D, 4'hF);
        do_read(32'h1000, 32'h0, 1'b0, -1);
        check("t6_alias", beats[0], 32'h0BAD_F00D);
        check("t6_n_beats", n_beats, 32'd4);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
